// File: rtl/accelerator_tensor_adder_scheduler.sv
`default_nettype none
// accelerator_tensor_adder_scheduler: drives one shared vector adder over an IxJxK tensor, one adder op per (i,j) row.
// Optional A/B dimension check at START is enabled by defining ACCELERATOR_TENSOR_SIZE_CHECK_EN.
module accelerator_tensor_adder_scheduler #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    output logic                 ERROR,
    input  logic                 OPERATION,
    input  logic [DATA_SIZE-1:0] SIZE_A_I_IN,
    input  logic [DATA_SIZE-1:0] SIZE_A_J_IN,
    input  logic [DATA_SIZE-1:0] SIZE_A_K_IN,
    input  logic [DATA_SIZE-1:0] SIZE_B_I_IN,
    input  logic [DATA_SIZE-1:0] SIZE_B_J_IN,
    input  logic [DATA_SIZE-1:0] SIZE_B_K_IN,
    input  logic                 DATA_IN_VALID,
    output logic                 DATA_IN_ACCEPT,
    input  logic [DATA_SIZE-1:0] DATA_A_IN,
    input  logic [DATA_SIZE-1:0] DATA_B_IN,
    output logic                 DATA_OUT_I_ENABLE,
    output logic                 DATA_OUT_J_ENABLE,
    output logic                 DATA_OUT_K_ENABLE,
    output logic [DATA_SIZE-1:0] DATA_OUT,
    output logic                 VA_START,
    input  logic                 VA_READY,
    output logic                 VA_OPERATION,
    output logic                 VA_DATA_A_IN_ENABLE,
    output logic                 VA_DATA_B_IN_ENABLE,
    output logic [DATA_SIZE-1:0] VA_SIZE_IN,
    output logic [DATA_SIZE-1:0] VA_DATA_A_IN,
    output logic [DATA_SIZE-1:0] VA_DATA_B_IN,
    input  logic                 VA_DATA_OUT_ENABLE,
    input  logic [DATA_SIZE-1:0] VA_DATA_OUT
);

    typedef enum logic [2:0] {
        STARTER   = 3'd0,
        ROW_START = 3'd1,
        ROW_FEED  = 3'd2,
        ROW_WAIT  = 3'd3,
        ENDER     = 3'd4
    } state_t;

    localparam logic [CONTROL_SIZE-1:0] c_one = CONTROL_SIZE'(1);

    state_t                  state_q, state_d;
    logic [CONTROL_SIZE-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
    logic [CONTROL_SIZE-1:0] lim_i_q, lim_i_d, lim_j_q, lim_j_d, lim_k_q, lim_k_d;
    logic [CONTROL_SIZE-1:0] ok_q, oj_q;
    logic [DATA_SIZE-1:0]    size_k_q, size_k_d;
    logic                    op_q, op_d;
    logic                    error_q, error_d;
    logic                    ready_q;
    logic                    va_en_q;
    logic [DATA_SIZE-1:0]    va_a_q, va_b_q;
    logic                    out_i_q, out_j_q, out_k_q;
    logic [DATA_SIZE-1:0]    data_out_q;

    logic [CONTROL_SIZE-1:0] w_ai, w_aj, w_ak;
    logic                    w_size_zero;
    logic                    w_mismatch;
    logic                    w_xfer;
    logic                    w_clear_out;

    assign w_ai        = CONTROL_SIZE'(SIZE_A_I_IN);
    assign w_aj        = CONTROL_SIZE'(SIZE_A_J_IN);
    assign w_ak        = CONTROL_SIZE'(SIZE_A_K_IN);
    assign w_size_zero = (w_ai == '0) || (w_aj == '0) || (w_ak == '0);

`ifdef ACCELERATOR_TENSOR_SIZE_CHECK_EN
    assign w_mismatch = (SIZE_A_I_IN != SIZE_B_I_IN) ||
                        (SIZE_A_J_IN != SIZE_B_J_IN) ||
                        (SIZE_A_K_IN != SIZE_B_K_IN);
`else
    // B dimensions carry no meaning without the check; the AND keeps them formally read.
    assign w_mismatch = 1'b0 & (|{SIZE_B_I_IN, SIZE_B_J_IN, SIZE_B_K_IN});
`endif

    assign DATA_IN_ACCEPT = (state_q == ROW_FEED);
    assign w_xfer         = DATA_IN_ACCEPT && DATA_IN_VALID;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= STARTER;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            lim_i_q  <= '0;
            lim_j_q  <= '0;
            lim_k_q  <= '0;
            size_k_q <= '0;
            op_q     <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            lim_i_q  <= lim_i_d;
            lim_j_q  <= lim_j_d;
            lim_k_q  <= lim_k_d;
            size_k_q <= size_k_d;
            op_q     <= op_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        lim_i_d     = lim_i_q;
        lim_j_d     = lim_j_q;
        lim_k_d     = lim_k_q;
        size_k_d    = size_k_q;
        op_d        = op_q;
        error_d     = error_q;
        w_clear_out = 1'b0;
        case (state_q)
            STARTER: begin
                if (START) begin
                    lim_i_d     = w_ai - c_one;
                    lim_j_d     = w_aj - c_one;
                    lim_k_d     = w_ak - c_one;
                    size_k_d    = SIZE_A_K_IN;
                    op_d        = OPERATION;
                    error_d     = 1'b0;
                    i_d         = '0;
                    j_d         = '0;
                    k_d         = '0;
                    w_clear_out = 1'b1;
                    if (w_mismatch) begin
                        error_d = 1'b1;
                        state_d = ENDER;
                    end else if (w_size_zero) begin
                        state_d = ENDER;
                    end else begin
                        state_d = ROW_START;
                    end
                end
            end
            ROW_START: begin
                k_d     = '0;
                state_d = ROW_FEED;
            end
            ROW_FEED: begin
                if (DATA_IN_VALID) begin
                    k_d = k_q + c_one;
                    if (k_q == lim_k_q) begin
                        state_d = ROW_WAIT;
                    end
                end
            end
            ROW_WAIT: begin
                if (VA_READY) begin
                    if (j_q == lim_j_q) begin
                        j_d = '0;
                        i_d = i_q + c_one;
                    end else begin
                        j_d = j_q + c_one;
                    end
                    state_d = ((i_q == lim_i_q) && (j_q == lim_j_q)) ? ENDER : ROW_START;
                end
            end
            ENDER: begin
                state_d = STARTER;
            end
            default: begin
                state_d = STARTER;
            end
        endcase
    end

    // Output framing counters run independently of the issue counters, so results
    // still retire correctly when VA_READY coincides with the last result strobe.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ready_q    <= 1'b0;
            va_en_q    <= 1'b0;
            va_a_q     <= '0;
            va_b_q     <= '0;
            out_i_q    <= 1'b0;
            out_j_q    <= 1'b0;
            out_k_q    <= 1'b0;
            data_out_q <= '0;
            ok_q       <= '0;
            oj_q       <= '0;
        end else begin
            ready_q <= (state_q == ENDER);
            va_en_q <= w_xfer;
            if (w_xfer) begin
                va_a_q <= DATA_A_IN;
                va_b_q <= DATA_B_IN;
            end
            out_k_q <= VA_DATA_OUT_ENABLE;
            out_j_q <= VA_DATA_OUT_ENABLE && (ok_q == '0);
            out_i_q <= VA_DATA_OUT_ENABLE && (ok_q == '0) && (oj_q == '0);
            if (VA_DATA_OUT_ENABLE) begin
                data_out_q <= VA_DATA_OUT;
            end
            if (w_clear_out) begin
                ok_q <= '0;
                oj_q <= '0;
            end else if (VA_DATA_OUT_ENABLE) begin
                if (ok_q == lim_k_q) begin
                    ok_q <= '0;
                    oj_q <= (oj_q == lim_j_q) ? '0 : oj_q + c_one;
                end else begin
                    ok_q <= ok_q + c_one;
                end
            end
        end
    end

    assign READY               = ready_q;
    assign ERROR               = error_q;
    assign VA_START            = (state_q == ROW_START);
    assign VA_OPERATION        = op_q;
    assign VA_SIZE_IN          = size_k_q;
    assign VA_DATA_A_IN_ENABLE = va_en_q;
    assign VA_DATA_B_IN_ENABLE = va_en_q;
    assign VA_DATA_A_IN        = va_a_q;
    assign VA_DATA_B_IN        = va_b_q;
    assign DATA_OUT_I_ENABLE   = out_i_q;
    assign DATA_OUT_J_ENABLE   = out_j_q;
    assign DATA_OUT_K_ENABLE   = out_k_q;
    assign DATA_OUT            = data_out_q;

endmodule
`default_nettype wire

// File: tb/tb_accelerator_tensor_adder_scheduler.sv
`default_nettype none
// Bench for accelerator_tensor_adder_scheduler: behavioural vector adder plus a tensor-order reference model,
// randomized sizes, data and upstream valid gaps.
module tb_accelerator_tensor_adder_scheduler;

    localparam int DW = 64;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          START = 1'b0;
    logic          OPERATION = 1'b0;
    logic [DW-1:0] SIZE_A_I_IN = '0, SIZE_A_J_IN = '0, SIZE_A_K_IN = '0;
    logic [DW-1:0] SIZE_B_I_IN = '0, SIZE_B_J_IN = '0, SIZE_B_K_IN = '0;
    logic          DATA_IN_VALID = 1'b0;
    logic [DW-1:0] DATA_A_IN = '0, DATA_B_IN = '0;
    logic          VA_READY = 1'b0;
    logic          VA_DATA_OUT_ENABLE = 1'b0;
    logic [DW-1:0] VA_DATA_OUT = '0;
    logic          READY, ERROR, DATA_IN_ACCEPT;
    logic          DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE, DATA_OUT_K_ENABLE;
    logic [DW-1:0] DATA_OUT;
    logic          VA_START, VA_OPERATION, VA_DATA_A_IN_ENABLE, VA_DATA_B_IN_ENABLE;
    logic [DW-1:0] VA_SIZE_IN, VA_DATA_A_IN, VA_DATA_B_IN;

    accelerator_tensor_adder_scheduler #(.DATA_SIZE(DW), .CONTROL_SIZE(DW)) dut (
        .CLK(CLK), .RST(RST), .START(START), .READY(READY), .ERROR(ERROR), .OPERATION(OPERATION),
        .SIZE_A_I_IN(SIZE_A_I_IN), .SIZE_A_J_IN(SIZE_A_J_IN), .SIZE_A_K_IN(SIZE_A_K_IN),
        .SIZE_B_I_IN(SIZE_B_I_IN), .SIZE_B_J_IN(SIZE_B_J_IN), .SIZE_B_K_IN(SIZE_B_K_IN),
        .DATA_IN_VALID(DATA_IN_VALID), .DATA_IN_ACCEPT(DATA_IN_ACCEPT),
        .DATA_A_IN(DATA_A_IN), .DATA_B_IN(DATA_B_IN),
        .DATA_OUT_I_ENABLE(DATA_OUT_I_ENABLE), .DATA_OUT_J_ENABLE(DATA_OUT_J_ENABLE),
        .DATA_OUT_K_ENABLE(DATA_OUT_K_ENABLE), .DATA_OUT(DATA_OUT),
        .VA_START(VA_START), .VA_READY(VA_READY), .VA_OPERATION(VA_OPERATION),
        .VA_DATA_A_IN_ENABLE(VA_DATA_A_IN_ENABLE), .VA_DATA_B_IN_ENABLE(VA_DATA_B_IN_ENABLE),
        .VA_SIZE_IN(VA_SIZE_IN), .VA_DATA_A_IN(VA_DATA_A_IN), .VA_DATA_B_IN(VA_DATA_B_IN),
        .VA_DATA_OUT_ENABLE(VA_DATA_OUT_ENABLE), .VA_DATA_OUT(VA_DATA_OUT)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [63:0] d;
        logic        j;
        logic        i;
    } exp_t;

    typedef struct packed {
        logic        v;
        logic        last;
        logic [63:0] d;
    } pipe_t;

    logic [63:0] a_mem[$];
    logic [63:0] b_mem[$];
    exp_t        exp_q[$];
    exp_t        e;
    pipe_t       pipe0 = '0, pipe1 = '0, new_p, out_p;
    real         ra, rb;
    int          idx, en_cnt, model_cnt, valid_pct;
    bit          prev_xfer;
    int          cyc, start_cyc, ready_cyc, vr_cyc, first_vs_cyc;
    int          n_vastart, n_ready, n_k, n_j, n_i;
    logic        tb_op;
    logic [63:0] tb_k;
    int          exp_rows, exp_elems;
    bit          exp_err;

    // Behavioural adder (2-cycle result latency, VA_READY with the row's last result),
    // upstream source and output monitor, all evaluated on the falling edge.
    always @(negedge CLK) begin
        cyc++;
        if (!RST) begin
            pipe0              = '0;
            pipe1              = '0;
            VA_READY           = 1'b0;
            VA_DATA_OUT_ENABLE = 1'b0;
            VA_DATA_OUT        = '0;
            model_cnt          = 0;
            prev_xfer          = 1'b0;
            DATA_IN_VALID      = 1'b0;
        end else begin
            if (START) start_cyc = cyc;
            if (READY) begin
                n_ready++;
                ready_cyc = cyc;
            end
            if (VA_START) begin
                n_vastart++;
                if (n_vastart == 1) first_vs_cyc = cyc;
                model_cnt = 0;
                check("va_operation", VA_OPERATION, tb_op);
                check("va_size", VA_SIZE_IN, tb_k);
            end
            new_p = '0;
            if (VA_DATA_A_IN_ENABLE || VA_DATA_B_IN_ENABLE) begin
                check("va_en_a", VA_DATA_A_IN_ENABLE, 1);
                check("va_en_b", VA_DATA_B_IN_ENABLE, 1);
                if (en_cnt < a_mem.size()) begin
                    check("va_data_a", VA_DATA_A_IN, a_mem[en_cnt]);
                    check("va_data_b", VA_DATA_B_IN, b_mem[en_cnt]);
                end else begin
                    check("va_en_extra", en_cnt, a_mem.size());
                end
                en_cnt++;
                model_cnt++;
                ra         = $bitstoreal(VA_DATA_A_IN);
                rb         = $bitstoreal(VA_DATA_B_IN);
                new_p.v    = 1'b1;
                new_p.d    = $realtobits(VA_OPERATION ? ra - rb : ra + rb);
                new_p.last = (64'(model_cnt) == VA_SIZE_IN);
            end
            if (DATA_OUT_K_ENABLE || DATA_OUT_J_ENABLE || DATA_OUT_I_ENABLE) begin
                check("out_k_en", DATA_OUT_K_ENABLE, 1);
                n_k++;
                n_j += int'(DATA_OUT_J_ENABLE);
                n_i += int'(DATA_OUT_I_ENABLE);
                if (exp_q.size() == 0) begin
                    check("out_extra", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("data_out", DATA_OUT, e.d);
                    check("out_j_en", DATA_OUT_J_ENABLE, e.j);
                    check("out_i_en", DATA_OUT_I_ENABLE, e.i);
                end
            end
            out_p = pipe1;
            pipe1 = pipe0;
            pipe0 = new_p;
            VA_DATA_OUT_ENABLE = out_p.v;
            VA_DATA_OUT        = out_p.v ? out_p.d : 64'(out_p.last);
            VA_READY           = out_p.last;
            if (out_p.last) vr_cyc = cyc;
            if (prev_xfer) idx++;
            DATA_IN_VALID = (idx < a_mem.size()) && ($urandom_range(99) < valid_pct);
            DATA_A_IN     = (idx < a_mem.size()) ? a_mem[idx] : 64'h0;
            DATA_B_IN     = (idx < b_mem.size()) ? b_mem[idx] : 64'h0;
            prev_xfer     = DATA_IN_VALID && DATA_IN_ACCEPT;
        end
    end

    task automatic launch(input int ni, input int nj, input int nk, input bit op, input int pct,
                          input bit fixed, input real fa, input real fb, input int bj);
        real a, b;
        @(posedge CLK);
        #2;
        a_mem.delete();
        b_mem.delete();
        exp_q.delete();
`ifdef ACCELERATOR_TENSOR_SIZE_CHECK_EN
        exp_err = (bj != nj);
`else
        exp_err = 1'b0;
`endif
        exp_rows  = (exp_err || ni * nj * nk == 0) ? 0 : ni * nj;
        exp_elems = (exp_rows == 0) ? 0 : ni * nj * nk;
        if (exp_rows != 0) begin
            for (int i = 0; i < ni; i++) begin
                for (int j = 0; j < nj; j++) begin
                    for (int k = 0; k < nk; k++) begin
                        a = fixed ? fa : real'($urandom_range(200)) - 100.0;
                        b = fixed ? fb : real'($urandom_range(200)) - 100.0;
                        a_mem.push_back($realtobits(a));
                        b_mem.push_back($realtobits(b));
                        exp_q.push_back('{d: $realtobits(op ? a - b : a + b),
                                          j: (k == 0), i: (k == 0 && j == 0)});
                    end
                end
            end
        end
        idx = 0; en_cnt = 0; prev_xfer = 1'b0; valid_pct = pct;
        n_vastart = 0; n_ready = 0; n_k = 0; n_j = 0; n_i = 0;
        start_cyc = -100; ready_cyc = -100; vr_cyc = -100; first_vs_cyc = -100;
        tb_op = op;
        tb_k  = 64'(nk);
        OPERATION   = op;
        SIZE_A_I_IN = 64'(ni); SIZE_A_J_IN = 64'(nj); SIZE_A_K_IN = 64'(nk);
        SIZE_B_I_IN = 64'(ni); SIZE_B_J_IN = 64'(bj); SIZE_B_K_IN = 64'(nk);
        START = 1'b1;
        @(posedge CLK);
        #2;
        START     = 1'b0;
        OPERATION = $urandom_range(1);
    endtask

    task automatic run(input int ni, input int nj, input int nk, input bit op, input int pct,
                       input bit fixed, input real fa, input real fb, input int bj);
        launch(ni, nj, nk, op, pct, fixed, fa, fb, bj);
        for (int c = 0; c < 5000 && n_ready == 0; c++) @(posedge CLK);
        repeat (4) @(posedge CLK);
        #2;
        check("ready_count", n_ready, 1);
        check("va_start_count", n_vastart, exp_rows);
        check("va_enable_count", en_cnt, exp_elems);
        check("k_strobe_count", n_k, exp_elems);
        check("j_strobe_count", n_j, exp_rows);
        check("i_strobe_count", n_i, (exp_rows == 0) ? 0 : ni);
        check("results_left", exp_q.size(), 0);
        check("error_flag", ERROR, exp_err);
        if (exp_rows != 0) begin
            check("start_to_va_start", 64'(first_vs_cyc - start_cyc), 1);
            check("va_ready_to_ready", 64'(vr_cyc - ready_cyc + 4), 2);
        end else begin
            check("start_to_ready", 64'(ready_cyc - start_cyc), 2);
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        valid_pct = 100;
        #3;
        check("rst_ctrl", {READY, ERROR, DATA_IN_ACCEPT, DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE,
                           DATA_OUT_K_ENABLE, VA_START, VA_OPERATION, VA_DATA_A_IN_ENABLE,
                           VA_DATA_B_IN_ENABLE}, 0);
        check("rst_data", |{DATA_OUT, VA_SIZE_IN, VA_DATA_A_IN, VA_DATA_B_IN}, 0);
        repeat (3) @(posedge CLK);
        #2;
        RST = 1'b1;

        run(2, 3, 4, 1'b0, 100, 1'b1, 1.0, 2.0, 3);
        run(1, 1, 1, 1'b1, 100, 1'b1, 5.0, 2.0, 1);
        run(2, 2, 0, 1'b0, 100, 1'b0, 0.0, 0.0, 2);
        run(1, 3, 2, 1'b0, 100, 1'b0, 0.0, 0.0, 4);
        run(2, 2, 8, 1'b1, 50, 1'b0, 0.0, 0.0, 2);
        for (int t = 0; t < 4; t++) begin
            int ri, rj, rk;
            ri = $urandom_range(3, 1);
            rj = $urandom_range(3, 1);
            rk = $urandom_range(5, 1);
            run(ri, rj, rk, 1'($urandom_range(1)), $urandom_range(100, 30), 1'b0, 0.0, 0.0, rj);
        end

        launch(2, 2, 8, 1'b1, 40, 1'b0, 0.0, 0.0, 2);
        for (int c = 0; c < 3000 && !(n_vastart == 3 && DATA_IN_ACCEPT); c++) @(negedge CLK);
        check("reached_row2_feed", {n_vastart == 3, DATA_IN_ACCEPT}, 2'b11);
        #1;
        RST = 1'b0;
        #1;
        check("midrun_rst_ctrl", {READY, ERROR, DATA_IN_ACCEPT, DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE,
                                  DATA_OUT_K_ENABLE, VA_START, VA_OPERATION, VA_DATA_A_IN_ENABLE,
                                  VA_DATA_B_IN_ENABLE}, 0);
        check("midrun_rst_data", |{DATA_OUT, VA_SIZE_IN, VA_DATA_A_IN, VA_DATA_B_IN}, 0);
        repeat (2) @(posedge CLK);
        #2;
        RST = 1'b1;
        n_vastart = 0;
        repeat (5) @(posedge CLK);
        #2;
        check("idle_after_rst", n_vastart, 0);
        run(2, 2, 3, 1'b0, 80, 1'b0, 0.0, 0.0, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
